// File: rtl/memoria_instrucciones_cargable.sv
// -----------------------------------------------------------------------------
// memoria_instrucciones_cargable
// Loadable instruction memory. After reset, every word is cleared to 0 (HLT),
// one word per cycle. Once clearing finishes, the memory serves registered
// fetches with a latency of one cycle, stall hold, and program-load writes.
//
// Optional build macro: MEM_INST_FWD_EN
//   defined   -> a fetch and a load to the same address in the same cycle
//                return the word being loaded (new data)
//   undefined -> the same case returns the previously stored word (old data)
// In both builds the memory is updated by the load.
// -----------------------------------------------------------------------------
module memoria_instrucciones_cargable #(
   parameter int ANCHO_DATO = 32,
   parameter int ANCHO_DIR  = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  leer,
   input  logic [ANCHO_DIR-1:0]  direccion,
   input  logic                  detener,
   input  logic                  cargar_en,
   input  logic [ANCHO_DIR-1:0]  cargar_dir,
   input  logic [ANCHO_DATO-1:0] cargar_dato,
   output logic [ANCHO_DATO-1:0] instruccion,
   output logic                  valida,
   output logic                  listo
);

   localparam int PROFUNDIDAD = 2 ** ANCHO_DIR;
   localparam logic [ANCHO_DIR-1:0] ULTIMA = {ANCHO_DIR{1'b1}};

   typedef enum logic {
      LIMPIAR = 1'b0,
      LISTO   = 1'b1
   } estado_t;

   estado_t               estado, estado_sig;
   logic [ANCHO_DIR-1:0]  contador, contador_sig;

   logic                  escribir;
   logic [ANCHO_DIR-1:0]  escr_dir;
   logic [ANCHO_DATO-1:0] escr_dato;
   logic [ANCHO_DATO-1:0] dato_leido;

   logic [ANCHO_DATO-1:0] mem [PROFUNDIDAD];

   // State register and clear counter.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (reset) begin
         estado   <= LIMPIAR;
         contador <= '0;
      end else begin
         estado   <= estado_sig;
         contador <= contador_sig;
      end
   end

   // Next state and write-port selection: clear writes while LIMPIAR, loads while LISTO.
   // NOTE: every output of this block gets a default first, so no path leaves a
   // signal unassigned and no latch is inferred.
   always_comb begin
      estado_sig   = estado;
      contador_sig = contador;
      escribir     = 1'b0;
      escr_dir     = contador;
      escr_dato    = '0;
      if (estado == LIMPIAR) begin
         escribir     = 1'b1;
         contador_sig = contador + 1'b1;
         if (contador == ULTIMA) begin
            estado_sig = LISTO;
         end
      end else begin
         escribir  = cargar_en;
         escr_dir  = cargar_dir;
         escr_dato = cargar_dato;
      end
   end

   // Single write port shared by the clear sweep and program loads; blocked during reset.
   // NOTE: the array itself has no reset branch -- it is cleared by the sweep
   // instead, which keeps it mappable onto block RAM.
   always_ff @(posedge clk) begin
      if (!reset && escribir) begin
         mem[escr_dir] <= escr_dato;
      end
   end

   // Read data for a fetch, with optional same-address forwarding of the load.
`ifdef MEM_INST_FWD_EN
   always_comb begin
      dato_leido = mem[direccion];
      if (cargar_en && (cargar_dir == direccion)) begin
         dato_leido = cargar_dato;
      end
   end
`else
   always_comb begin
      dato_leido = mem[direccion];
   end
`endif

   // Registered fetch: load on leer, hold on detener, drop valida when idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         instruccion <= '0;
         valida      <= 1'b0;
      end else if (estado == LISTO && !detener) begin
         if (leer) begin
            instruccion <= dato_leido;
            valida      <= 1'b1;
         end else begin
            valida      <= 1'b0;
         end
      end
   end

   assign listo = (estado == LISTO);

endmodule

// File: tb/tb_memoria_instrucciones_cargable.sv
// -----------------------------------------------------------------------------
// tb_memoria_instrucciones_cargable
// Self-checking bench for memoria_instrucciones_cargable (ANCHO_DATO=32,
// ANCHO_DIR=4). A behavioural model tracks memory contents, the fetch register
// and readiness; directed scenarios are followed by randomized traffic.
// Compile with MEM_INST_FWD_EN defined to check the forwarding build.
// -----------------------------------------------------------------------------
module tb_memoria_instrucciones_cargable;

   localparam int AD = 32;
   localparam int AA = 4;
   localparam int N  = 2 ** AA;

   logic          clk = 1'b0;
   logic          reset, leer, detener, cargar_en;
   logic [AA-1:0] direccion, cargar_dir;
   logic [AD-1:0] cargar_dato;
   logic [AD-1:0] instruccion;
   logic          valida, listo;

   always #5 clk = ~clk;

   memoria_instrucciones_cargable #(
      .ANCHO_DATO (AD),
      .ANCHO_DIR  (AA)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .leer        (leer),
      .direccion   (direccion),
      .detener     (detener),
      .cargar_en   (cargar_en),
      .cargar_dir  (cargar_dir),
      .cargar_dato (cargar_dato),
      .instruccion (instruccion),
      .valida      (valida),
      .listo       (listo)
   );

   int errores = 0;
   int total   = 0;

   // Reference model state
   logic [AD-1:0] m_mem [N];
   logic [AD-1:0] m_inst;
   logic          m_val;
   int            m_ciclos;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      total++;
      if (obs !== esp) begin
         errores++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, esp, $time);
      end
   endtask

   // One clock cycle: drive on the falling edge, advance the model at the
   // rising edge, then compare all outputs shortly after it.
   task automatic ciclo(input logic r, input logic l, input logic [AA-1:0] d,
                        input logic det, input logic ce, input logic [AA-1:0] cd,
                        input logic [AD-1:0] cdat);
      @(negedge clk);
      reset = r; leer = l; direccion = d; detener = det;
      cargar_en = ce; cargar_dir = cd; cargar_dato = cdat;
      @(posedge clk);
      if (r) begin
         // Reset discards everything; the clear sweep leaves all words at 0.
         m_inst   = '0;
         m_val    = 1'b0;
         m_ciclos = 0;
         foreach (m_mem[i]) m_mem[i] = '0;
      end else if (m_ciclos < N) begin
         m_ciclos++;
      end else begin
         if (!det) begin
            if (l) begin
               m_inst = m_mem[d];
`ifdef MEM_INST_FWD_EN
               if (ce && cd == d) m_inst = cdat;
`endif
               m_val = 1'b1;
            end else begin
               m_val = 1'b0;
            end
         end
         if (ce) m_mem[cd] = cdat;
      end
      #1;
      check("instruccion", instruccion, m_inst);
      check("valida", {31'b0, valida}, {31'b0, m_val});
      check("listo", {31'b0, listo}, {31'b0, (m_ciclos >= N)});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) ciclo(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic fetch(input logic [AA-1:0] d);
      ciclo(1'b0, 1'b1, d, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic load(input logic [AA-1:0] a, input logic [AD-1:0] v);
      ciclo(1'b0, 1'b0, '0, 1'b0, 1'b1, a, v);
   endtask

   task automatic do_reset();
      ciclo(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   // Counts cycles until listo rises, starting from 'ya' cycles already spent.
   task automatic esperar_listo(input int ya, input string tag);
      int lat;
      lat = ya;
      while (!listo && lat < 4 * N) begin
         idle(1);
         lat++;
      end
      check(tag, lat, N);
   endtask

   initial begin
      logic          r, l, det, ce;
      logic [AA-1:0] d, cd;

      do_reset();
      do_reset();
      esperar_listo(0, "latencia_listo");

      fetch(4'd9);
      check("fetch_limpio", instruccion, 32'h0000_0000);
      check("fetch_limpio_valida", {31'b0, valida}, 32'd1);

      load(4'd3, 32'h0021_0820);
      load(4'd5, 32'h1234_5678);
      fetch(4'd3);
      check("carga_fetch", instruccion, 32'h0021_0820);

      for (int i = 0; i < 3; i++) ciclo(1'b0, 1'b1, 4'd5, 1'b1, 1'b0, '0, '0);
      check("detener_inst", instruccion, 32'h0021_0820);
      check("detener_valida", {31'b0, valida}, 32'd1);
      fetch(4'd5);
      check("tras_detener", instruccion, 32'h1234_5678);

      idle(1);
      check("reposo_valida", {31'b0, valida}, 32'd0);
      check("reposo_inst", instruccion, 32'h1234_5678);

      load(4'd7, 32'h8C01_0001);
      ciclo(1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 4'd7, 32'h0023_1020);
`ifdef MEM_INST_FWD_EN
      check("rdw_mismo", instruccion, 32'h0023_1020);
`else
      check("rdw_mismo", instruccion, 32'h8C01_0001);
`endif
      fetch(4'd7);
      check("rdw_despues", instruccion, 32'h0023_1020);

      // Fetch and load to different addresses in the same cycle.
      ciclo(1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 4'd0, 32'hCAFE_F00D);
      check("simult_fetch", instruccion, 32'h0021_0820);
      fetch(4'd0);
      check("simult_carga", instruccion, 32'hCAFE_F00D);

      // Reset in the middle of the clear restarts it.
      do_reset();
      idle(8);
      do_reset();
      esperar_listo(0, "latencia_reinicio");

      // Loaded contents are lost on reset; activity during clear is ignored.
      load(4'd15, 32'hDEAD_BEEF);
      fetch(4'd15);
      check("carga_15", instruccion, 32'hDEAD_BEEF);
      do_reset();
      for (int i = 0; i < 4; i++) ciclo(1'b0, 1'b1, 4'd15, 1'b0, 1'b1, 4'd2, 32'hAAAA_5555);
      check("limpiar_valida", {31'b0, valida}, 32'd0);
      esperar_listo(4, "latencia_con_pulsos");
      fetch(4'd15);
      check("tras_reset_15", instruccion, 32'h0000_0000);
      fetch(4'd2);
      check("carga_ignorada", instruccion, 32'h0000_0000);

      // Randomized traffic; same-address collisions are made frequent.
      for (int i = 0; i < 800; i++) begin
         r   = ($urandom_range(0, 149) == 0);
         l   = ($urandom_range(0, 3) != 0);
         det = ($urandom_range(0, 4) == 0);
         ce  = ($urandom_range(0, 1) == 0);
         d   = AA'($urandom_range(0, N - 1));
         cd  = ($urandom_range(0, 2) == 0) ? d : AA'($urandom_range(0, N - 1));
         ciclo(r, l, d, det, ce, cd, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errores, total);
      $finish;
   end

endmodule
